// File: rtl/reg_bank_arbiter.sv
// ============================================================================
// reg_bank_arbiter : round-robin shared-write arbiter for a small register bank
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_bank_arbiter #(
  parameter int                    DATA_WIDTH = 4,
  parameter int                    ADDR_WIDTH = 2,
  parameter int                    NUM_REQ    = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                             C,
  input  logic                             CLR,
  input  logic [NUM_REQ-1:0]               REQ,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    WADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    WDATA,
  output logic [NUM_REQ-1:0]               GNT,
  output logic [NUM_REQ-1:0]               ACK,
  output logic                             BUSY,
  input  logic [ADDR_WIDTH-1:0]            RADDR,
  output logic [DATA_WIDTH-1:0]            RDATA
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state;
  logic [PTR_W-1:0]        ptr;
  logic [PTR_W-1:0]        win;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic [DATA_WIDTH-1:0]   bank [DEPTH];

  logic [PTR_W-1:0]        win_idx;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin : arb_search
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    logic             found;
    win_idx  = ptr;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = cand[PTR_W-1:0];
      if (!found && REQ[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        sel_addr = WADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = WDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge C or negedge CLR) begin
    if (!CLR) begin
      state    <= IDLE;
      GNT      <= '0;
      ACK      <= '0;
      ptr      <= '0;
      win      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= INIT_VAL;
      end
    end else begin
      case (state)
        IDLE: begin
          if (|REQ) begin
            GNT      <= onehot(win_idx);
            win      <= win_idx;
            lat_addr <= sel_addr;
            lat_data <= sel_data;
            state    <= GRANT;
          end
        end
        GRANT: begin
          bank[lat_addr] <= lat_data;
          GNT            <= '0;
          ACK            <= onehot(win);
          ptr            <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          state          <= DONE;
        end
        DONE: begin
          // REQ is deliberately not sampled here; the requester drops it on ACK.
          ACK   <= '0;
          state <= IDLE;
        end
        default: begin
          GNT   <= '0;
          ACK   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign BUSY  = (state != IDLE);
  assign RDATA = bank[RADDR];

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
// ============================================================================
// tb_reg_bank_arbiter : scoreboard bench for reg_bank_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_bank_arbiter;
  localparam int N     = 4;
  localparam int AW    = 2;
  localparam int DW    = 4;
  localparam int DEPTH = 4;

  logic            C = 1'b0;
  logic            CLR;
  logic [N-1:0]    REQ;
  logic [N*AW-1:0] WADDR;
  logic [N*DW-1:0] WDATA;
  logic [N-1:0]    GNT;
  logic [N-1:0]    ACK;
  logic            BUSY;
  logic [AW-1:0]   RADDR;
  logic [DW-1:0]   RDATA;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [N-1:0]  exp_gnt [$];
  logic [N-1:0]  exp_ack [$];
  int            gnt_cyc [$];
  logic [N-1:0]  gnt_val [$];

  int            mptr;
  logic [DW-1:0] mbank [DEPTH];

  reg_bank_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REQ   (N),
    .INIT_VAL  ('0)
  ) dut (
    .C    (C),
    .CLR  (CLR),
    .REQ  (REQ),
    .WADDR(WADDR),
    .WDATA(WDATA),
    .GNT  (GNT),
    .ACK  (ACK),
    .BUSY (BUSY),
    .RADDR(RADDR),
    .RDATA(RDATA)
  );

  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    WADDR[i*AW +: AW] = a;
    WDATA[i*DW +: DW] = d;
  endtask

  // Predict the whole service order for the REQ now driven, assuming each
  // requester drops its bit on its ACK and nobody new arrives.
  task automatic predict();
    logic [N-1:0] r;
    logic [N-1:0] oh;
    int           w;
    r = REQ;
    while (r != '0) begin
      w     = pick(r, mptr);
      oh    = '0;
      oh[w] = 1'b1;
      exp_gnt.push_back(oh);
      exp_ack.push_back(oh);
      mbank[WADDR[w*AW +: AW]] = WDATA[w*DW +: DW];
      mptr  = (w + 1) % N;
      r[w]  = 1'b0;
    end
  endtask

  task automatic run_txn(input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge C);
      REQ = REQ & ~ACK;
      n++;
    end while ((REQ != '0 || BUSY) && n < max_cycles);
    if (REQ != '0 || BUSY) check("txn_timeout", 32'(n), 32'(max_cycles + 1));
  endtask

  task automatic check_bank();
    for (int a = 0; a < DEPTH; a++) begin
      RADDR = AW'(a);
      #1;
      check($sformatf("bank%0d", a), 32'(RDATA), 32'(mbank[a]));
    end
  endtask

  task automatic do_reset();
    CLR = 1'b0;
    REQ = '0;
    #2;
    check("rst_gnt", 32'(GNT), 32'(0));
    check("rst_ack", 32'(ACK), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    CLR  = 1'b1;
    mptr = 0;
    for (int a = 0; a < DEPTH; a++) mbank[a] = '0;
  endtask

  // Output monitor: pops the scoreboard whenever GNT or ACK pulses.
  initial begin
    forever begin
      @(negedge C);
      cyc++;
      if (GNT != '0) begin
        gnt_cyc.push_back(cyc);
        gnt_val.push_back(GNT);
        if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(GNT), 32'(0));
        else                     check("gnt", 32'(GNT), 32'(exp_gnt.pop_front()));
      end
      if (ACK != '0) begin
        if (exp_ack.size() == 0) check("ack_unexpected", 32'(ACK), 32'(0));
        else                     check("ack", 32'(ACK), 32'(exp_ack.pop_front()));
        if (gnt_cyc.size() != 0) check("ack_latency", 32'(cyc - gnt_cyc[$]), 32'(1));
      end
      if ((GNT & ACK) != '0) check("gnt_ack_excl", 32'(GNT & ACK), 32'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n0;
    CLR   = 1'b0;
    REQ   = '0;
    WADDR = '0;
    WDATA = '0;
    RADDR = '0;

    // Reset state
    do_reset();
    @(negedge C);
    check_bank();

    // Single write from requester 0
    @(negedge C);
    RADDR = 2'd2;
    set_req(0, 2'd2, 4'hA);
    REQ = 4'b0001;
    predict();
    @(negedge C);
    check("single_busy_grant", 32'(BUSY), 32'(1));
    check("single_rd_old", 32'(RDATA), 32'(0));
    @(negedge C);
    check("single_busy_ack", 32'(BUSY), 32'(1));
    check("single_rd_new", 32'(RDATA), 32'hA);
    REQ = REQ & ~ACK;
    @(negedge C);
    check("single_busy_end", 32'(BUSY), 32'(0));

    // Full contention from pointer 0
    do_reset();
    @(negedge C);
    for (int i = 0; i < N; i++) set_req(i, AW'(i), DW'(i + 1));
    REQ = 4'b1111;
    predict();
    n0 = gnt_cyc.size();
    run_txn(40);
    check("cont_grants", 32'(gnt_cyc.size() - n0), 32'(4));
    if (gnt_cyc.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("cont_order%0d", i), 32'(gnt_val[n0+i]), 32'(1 << i));
      for (int i = 1; i < 4; i++) check($sformatf("cont_space%0d", i), 32'(gnt_cyc[n0+i] - gnt_cyc[n0+i-1]), 32'(3));
    end
    check_bank();

    // Fairness: requester 0 served, then 0 and 1 contend
    @(negedge C);
    set_req(0, 2'd0, 4'h7);
    REQ = 4'b0001;
    predict();
    run_txn(20);
    @(negedge C);
    set_req(0, 2'd3, 4'h8);
    set_req(1, 2'd2, 4'h9);
    REQ = 4'b0011;
    predict();
    n0 = gnt_cyc.size();
    run_txn(30);
    if (gnt_val.size() >= n0 + 2) begin
      check("fair_first", 32'(gnt_val[n0]), 32'b0010);
      check("fair_second", 32'(gnt_val[n0+1]), 32'b0001);
    end else begin
      check("fair_grants", 32'(gnt_val.size() - n0), 32'(2));
    end
    check_bank();

    // Collision on address 1 with pointer at 2
    @(negedge C);
    set_req(1, 2'd0, 4'h3);
    REQ = 4'b0010;
    predict();
    run_txn(20);
    @(negedge C);
    set_req(2, 2'd1, 4'h5);
    set_req(3, 2'd1, 4'h6);
    REQ = 4'b1100;
    predict();
    run_txn(30);
    RADDR = 2'd1;
    #1;
    check("collide_last_wins", 32'(RDATA), 32'h6);
    check_bank();

    // Move pointer to 2, then abort a write with reset during GRANT
    @(negedge C);
    set_req(1, 2'd2, 4'hC);
    REQ = 4'b0010;
    predict();
    run_txn(20);
    @(negedge C);
    set_req(3, 2'd3, 4'hF);
    REQ = 4'b1000;
    @(posedge C);
    #1;
    check("midop_gnt", 32'(GNT), 32'b1000);
    check("midop_busy", 32'(BUSY), 32'(1));
    CLR = 1'b0;
    REQ = '0;
    #1;
    check("midop_gnt_drop", 32'(GNT), 32'(0));
    check("midop_ack_drop", 32'(ACK), 32'(0));
    check("midop_busy_drop", 32'(BUSY), 32'(0));
    #1;
    CLR  = 1'b1;
    mptr = 0;
    for (int a = 0; a < DEPTH; a++) mbank[a] = '0;
    repeat (4) @(negedge C);
    check_bank();

    // Pointer must be back at 0: requester 0 wins over 3
    @(negedge C);
    set_req(0, 2'd0, 4'h1);
    set_req(3, 2'd3, 4'h2);
    REQ = 4'b1001;
    predict();
    n0 = gnt_val.size();
    run_txn(30);
    if (gnt_val.size() > n0) check("ptr_after_rst", 32'(gnt_val[n0]), 32'b0001);
    else                     check("ptr_after_rst_grants", 32'(0), 32'(2));
    check_bank();

    repeat (2) @(negedge C);
    check("sb_gnt_empty", 32'(exp_gnt.size()), 32'(0));
    check("sb_ack_empty", 32'(exp_ack.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
